mtm_unit: RTL and testbench
===========================

Name: mtm_unit

Overview:
- Streaming square-matrix transpose unit for the HE-acceleration datapath.
- Accepts an NUM_PE x NUM_PE matrix one row per valid cycle and emits the transposed matrix one row per cycle, i.e. column c of the input as output row c.
- Ping-pong buffered, so a new matrix can be loaded while the previous one drains.
- Sits between row-oriented producer PEs and column-oriented consumer PEs.

Parameters:
- DATA_WIDTH, 8: bit width of each matrix element.
- NUM_PE, 4: matrix dimension, equal to elements per row and rows per matrix. Must be at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low. Asserting rst (rst=0) clears all state immediately, independent of clk.
- val  input  1  input_row holds a valid matrix row this cycle.
- input_row  input  NUM_PE x DATA_WIDTH, unpacked [0:NUM_PE-1]  one input matrix row; element j is column j.
- out_val  output  1  output_row holds a valid transposed row this cycle.
- output_row  output  NUM_PE x DATA_WIDTH, unpacked [0:NUM_PE-1]  one transposed row; element i is input row i.

Behaviour:
- Storage: two banks (A, B), each NUM_PE x NUM_PE x DATA_WIDTH registers.
- Write pointer selects the fill bank; row counter wr_row runs 0..NUM_PE-1.
- Each bank has a full flag.
- Read side has a drain bank select and column counter rd_col, 0..NUM_PE-1.
- Reset (rst=0, asynchronous):
  - counters = 0; both full flags = 0; fill bank = A; drain bank = A.
  - out_val = 0; output_row = all zeros; bank contents = zeros.
- Fill side, on a rising edge with val=1:
  - input_row is written to fill bank row wr_row, then wr_row increments.
  - val=0 cycles are bubbles: wr_row holds, and rows need not be consecutive.
  - When row NUM_PE-1 is written (edge E), the bank's full flag sets, wr_row wraps to 0, and the fill bank toggles.
- Drain side: while the drain bank is full, on each rising edge:
  - output_row[i] <= bank[i][rd_col] for every i; out_val <= 1; rd_col increments.
  - After column NUM_PE-1, clear that bank's full flag, wrap rd_col to 0, and toggle the drain bank.
- When the drain bank is not full, on each rising edge out_val <= 0.
- Latency:
  - The first transposed row is registered at edge E+1, after the last-row edge E.
  - out_val is high for exactly NUM_PE consecutive cycles, registered at edges E+1..E+NUM_PE.
- Back-to-back matrices (val held high continuously): the next last-row edge is at the earliest E+NUM_PE and its drain starts at E+NUM_PE+1. Output is then continuous, with no gap and no overlap.
- Overflow: a write to a fill bank whose full flag is still set is impossible at the minimum fill time of NUM_PE cycles. If it ever occurs, the row is dropped and wr_row holds. No backpressure port.
- Simultaneous fill-complete and drain-complete on the same bank edge: the full flag ends set. The set wins over the clear, since they target different banks; the same bank only happens after an overflow, which is blocked.
- Reset mid-operation: all partially loaded and draining matrices are discarded. out_val drops asynchronously to 0.
- Arithmetic: data passes through unmodified, with no width change. Counters are $clog2(NUM_PE) bits.

Optional Feature:
- Macro MTM_ZERO_IDLE_EN.
- Defined: output_row is driven to all zeros in every cycle where out_val=0.
- Undefined: output_row holds the last transposed row after out_val falls. It changes only on edges where out_val is asserted.
- out_val timing is identical in both builds.

Test Plan:
- Reset: hold rst=0 with random val/input_row for 3 cycles -> out_val=0 and output_row all zeros. Asserting rst mid-drain -> out_val 0 immediately, with no edge required.
- Single matrix: M[i][j]=0x10*i+0x0A+j, rows 0..3 on 4 consecutive val cycles, then val=0 -> out_val high for 4 cycles starting one edge after row 3.
  - Rows {0A,1A,2A,3A}, {0B,1B,2B,3B}, {0C,1C,2C,3C}, {0D,1D,2D,3D} in order.
  - Then out_val=0.
- Bubbles: same matrix with val=0 cycles inserted between rows 1 and 2 -> identical output sequence, starting one edge after the row-3 edge.
- Back-to-back: the above matrix followed immediately by an all-zero matrix, val continuously high for 8 cycles -> 8 contiguous out_val cycles: the 4 transposed rows above, then 4 all-zero rows.
- Partial then reset: load 2 rows, pulse rst=0, then load the full test matrix -> output equals the single-matrix case, with no stale rows.
- MTM_ZERO_IDLE_EN: after the drain completes, output_row = 0 when defined; output_row = {0D,1D,2D,3D} held when undefined.

Source files
------------

// File: rtl/mtm_unit.sv
// Streaming square-matrix transpose with ping-pong banks.
// Rows are written into the fill bank. A full bank is drained one column per cycle,
// so output row c is column c of the loaded matrix.
// Optional build macro: MTM_ZERO_IDLE_EN
//   Defined:   output_row is forced to zero in every cycle where out_val is low.
//   Undefined: output_row holds the last transposed row.
module mtm_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PE     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  val,
  input  logic [DATA_WIDTH-1:0] input_row  [0:NUM_PE-1],
  output logic                  out_val,
  output logic [DATA_WIDTH-1:0] output_row [0:NUM_PE-1]
);

  localparam int unsigned CntW = $clog2(NUM_PE);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_PE - 1);

  logic [DATA_WIDTH-1:0] bank_q [2][NUM_PE][NUM_PE];
  logic [DATA_WIDTH-1:0] bank_d [2][NUM_PE][NUM_PE];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [CntW-1:0]       wr_row_q, wr_row_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [CntW-1:0]       rd_col_q, rd_col_d;
  logic                  out_val_q, out_val_d;
  logic [DATA_WIDTH-1:0] output_row_q [NUM_PE];
  logic [DATA_WIDTH-1:0] output_row_d [NUM_PE];
  logic                  wr_en, rd_en;

  // Next-state for fill side, drain side and full flags
  always_comb begin
    bank_d       = bank_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    wr_row_d     = wr_row_q;
    rd_bank_d    = rd_bank_q;
    rd_col_d     = rd_col_q;
    out_val_d    = 1'b0;
    output_row_d = output_row_q;

    // A write into a still-full bank is dropped and wr_row holds.
    wr_en = val && !full_q[wr_bank_q];
    rd_en = full_q[rd_bank_q];

    if (rd_en) begin
      for (int i = 0; i < NUM_PE; i++) begin
        output_row_d[i] = bank_q[rd_bank_q][i][rd_col_q];
      end
      out_val_d = 1'b1;
      if (rd_col_q == LastIdx) begin
        full_d[rd_bank_q] = 1'b0;
        rd_col_d          = '0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_col_d = rd_col_q + CntW'(1);
      end
    end else begin
`ifdef MTM_ZERO_IDLE_EN
      for (int i = 0; i < NUM_PE; i++) begin
        output_row_d[i] = '0;
      end
`endif
    end

    // The fill update follows the drain update, so a set wins over a clear.
    if (wr_en) begin
      for (int j = 0; j < NUM_PE; j++) begin
        bank_d[wr_bank_q][wr_row_q][j] = input_row[j];
      end
      if (wr_row_q == LastIdx) begin
        full_d[wr_bank_q] = 1'b1;
        wr_row_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + CntW'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < NUM_PE; r++) begin
          for (int c = 0; c < NUM_PE; c++) begin
            bank_q[b][r][c] <= '0;
          end
        end
      end
      for (int i = 0; i < NUM_PE; i++) begin
        output_row_q[i] <= '0;
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= '0;
      out_val_q <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      output_row_q <= output_row_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_row_q     <= wr_row_d;
      rd_bank_q    <= rd_bank_d;
      rd_col_q     <= rd_col_d;
      out_val_q    <= out_val_d;
    end
  end

  assign out_val    = out_val_q;
  assign output_row = output_row_q;

endmodule

// File: tb/tb_mtm_unit.sv
// Self-checking bench for mtm_unit.
// The reference model collects whole matrices. When a matrix completes at some edge,
// it schedules the transposed rows for the edges where that matrix drains.
module tb_mtm_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned RW = DW * NP;
`ifdef MTM_ZERO_IDLE_EN
  localparam bit ZeroIdle = 1'b1;
`else
  localparam bit ZeroIdle = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          val;
  logic [DW-1:0] input_row  [0:NP-1];
  logic          out_val;
  logic [DW-1:0] output_row [0:NP-1];

  mtm_unit #(
    .DATA_WIDTH(DW),
    .NUM_PE    (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .val       (val),
    .input_row (input_row),
    .out_val   (out_val),
    .output_row(output_row)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;           // edges seen
  int next_free = 0;   // first edge the drain side is free
  int nrows = 0;
  logic [RW-1:0] mat [NP];
  logic [RW-1:0] exp_rows [int];
  logic [RW-1:0] last_row = '0;

  task automatic check_val(input string tag, input logic [RW-1:0] got,
                           input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Element k of a packed row; element 0 sits in the most significant byte
  function automatic logic [DW-1:0] elem(input logic [RW-1:0] r, input int k);
    return r[(NP-1-k)*DW +: DW];
  endfunction

  function automatic logic [RW-1:0] pack_out();
    logic [RW-1:0] p;
    for (int k = 0; k < NP; k++) p[(NP-1-k)*DW +: DW] = output_row[k];
    return p;
  endfunction

  function automatic logic [RW-1:0] test_row(input int i);
    logic [RW-1:0] p;
    for (int j = 0; j < NP; j++) p[(NP-1-j)*DW +: DW] = DW'(8'h10 * i + 8'h0A + j);
    return p;
  endfunction

  task automatic model_reset();
    exp_rows.delete();
    nrows     = 0;
    next_free = 0;
    last_row  = '0;
  endtask

  task automatic model_edge(input bit v, input logic [RW-1:0] row);
    int start;
    logic [RW-1:0] col;
    if (v) begin
      mat[nrows] = row;
      nrows++;
      if (nrows == NP) begin
        start = (n + 1 > next_free) ? n + 1 : next_free;
        for (int c = 0; c < NP; c++) begin
          for (int i = 0; i < NP; i++) col[(NP-1-i)*DW +: DW] = elem(mat[i], c);
          exp_rows[start + c] = col;
        end
        next_free = start + NP;
        nrows = 0;
      end
    end
  endtask

  task automatic compare();
    if (exp_rows.exists(n)) begin
      check_val("out_val_hi", RW'(out_val), RW'(1));
      check_val("out_row", pack_out(), exp_rows[n]);
      last_row = exp_rows[n];
      exp_rows.delete(n);
    end else begin
      check_val("out_val_lo", RW'(out_val), '0);
      check_val("idle_row", pack_out(), ZeroIdle ? '0 : last_row);
    end
  endtask

  task automatic tick(input bit v, input logic [RW-1:0] row);
    val = v;
    for (int k = 0; k < NP; k++) input_row[k] = elem(row, k);
    @(posedge clk);
    n++;
    if (rst) model_edge(v, row);
    #1;
    if (rst) begin
      compare();
    end else begin
      check_val("rst_out_val", RW'(out_val), '0);
      check_val("rst_out_row", pack_out(), '0);
    end
  endtask

  task automatic load_test_matrix();
    for (int i = 0; i < NP; i++) tick(1'b1, test_row(i));
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) tick(1'b0, RW'($urandom));
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge
  task automatic async_reset();
    rst = 1'b0;
    #1;
    check_val("async_out_val", RW'(out_val), '0);
    check_val("async_out_row", pack_out(), '0);
    model_reset();
    tick(1'b0, RW'($urandom));
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    val = 1'b0;
    for (int k = 0; k < NP; k++) input_row[k] = '0;
    #1;
    check_val("init_out_val", RW'(out_val), '0);
    for (int c = 0; c < 3; c++) tick(1'($urandom), RW'($urandom));
    rst = 1'b1;
    model_reset();

    // Single matrix
    load_test_matrix();
    idle(6);

    // Bubbles between rows 1 and 2
    tick(1'b1, test_row(0));
    tick(1'b1, test_row(1));
    idle(3);
    tick(1'b1, test_row(2));
    tick(1'b1, test_row(3));
    idle(6);

    // Back-to-back: test matrix then an all-zero matrix
    load_test_matrix();
    for (int i = 0; i < NP; i++) tick(1'b1, '0);
    idle(6);

    // Partial load, then reset, then a full matrix
    tick(1'b1, test_row(0));
    tick(1'b1, test_row(1));
    async_reset();
    load_test_matrix();
    idle(6);

    // Reset while draining
    load_test_matrix();
    idle(2);
    async_reset();
    idle(3);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      tick($urandom_range(0, 3) != 0, RW'($urandom));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
